acc_display: RTL and testbench

//   Result-side counterpart of the calculator ALU: takes the 16-bit accumulator/ALU

---
 rtl/acc_display.sv | 183 ++++++++++++++++++
 tb/tb_acc_display.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/acc_display.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | acc_display: 16-bit result -> 5-digit BCD (double-dabble) + 6-position   |
// | muxed 7-segment driver. Optional macro: SIGNED_DISPLAY_EN.               |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module acc_display #(
  parameter int REFRESH_DIV = 1000,
  parameter int BLANK_LZ    = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] value,
  output logic        busy,
  output logic        done,
  output logic [19:0] bcd_out,
  output logic        neg,
  output logic [5:0]  an,
  output logic [6:0]  seg
);

  localparam int              c_cntW     = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [c_cntW-1:0] c_cntMax = c_cntW'(REFRESH_DIV - 1);
  localparam logic            c_blankLz  = (BLANK_LZ != 0);
  localparam logic [6:0]      c_segBlank = 7'b1111111;
  localparam logic [6:0]      c_segMinus = 7'b0111111;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_CONV = 1'b1
  } state_t;

  state_t r_state, w_stateNext;
  logic        w_accept, w_last;
  logic [3:0]  r_iter;
  logic [18:0] r_bcd;
  logic [15:0] r_bin;
  logic [19:0] r_bcdOut;
  logic        r_done;
  logic [15:0] w_mag;
  logic [15:0] w_adj;
  logic [19:0] w_bcdNext;
  logic [15:0] w_binNext;
  logic [6:0]  w_signSeg;

  logic [c_cntW-1:0] r_refCnt;
  logic [2:0]        r_scanIdx;
  logic [19:0]       w_upper;
  logic              w_blank;

  // ---------------------------------------------------------------- sign
`ifdef SIGNED_DISPLAY_EN
  logic r_negPend, r_neg;
  assign w_mag     = value[15] ? (16'd0 - value) : value;
  assign neg       = r_neg;
  assign w_signSeg = r_neg ? c_segMinus : c_segBlank;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_negPend <= 1'b0;
      r_neg     <= 1'b0;
    end else begin
      if (w_accept) r_negPend <= value[15];
      if (w_last)   r_neg     <= r_negPend;
    end
  end
`else
  assign w_mag     = value;
  assign neg       = 1'b0;
  assign w_signSeg = c_segBlank;
`endif

  // ---------------------------------------------------------------- control
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (load) begin
          w_accept    = 1'b1;
          w_stateNext = S_CONV;
        end
      end
      S_CONV: begin
        if (r_iter == 4'd15) begin
          w_last      = 1'b1;
          w_stateNext = S_IDLE;
        end
      end
      default: w_stateNext = S_IDLE;
    endcase
  end

  assign busy    = (r_state == S_CONV);
  assign done    = r_done;
  assign bcd_out = r_bcdOut;

  // ---------------------------------------------------------------- shift-add-3
  // The top digit never reaches 5 before the final shift (input < 65536),
  // so only the lower four nibbles need correction and r_bcd holds 19 bits.
  for (genvar gi = 0; gi < 4; gi++) begin : g_adj
    assign w_adj[gi*4 +: 4] = (r_bcd[gi*4 +: 4] >= 4'd5) ? r_bcd[gi*4 +: 4] + 4'd3
                                                         : r_bcd[gi*4 +: 4];
  end

  assign w_bcdNext = {r_bcd[18:16], w_adj, r_bin[15]};
  assign w_binNext = {r_bin[14:0], 1'b0};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_iter   <= 4'd0;
      r_bcd    <= 19'd0;
      r_bin    <= 16'd0;
      r_bcdOut <= 20'd0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_iter <= 4'd0;
        r_bcd  <= 19'd0;
        r_bin  <= w_mag;
      end else if (r_state == S_CONV) begin
        r_iter <= r_iter + 4'd1;
        r_bcd  <= w_bcdNext[18:0];
        r_bin  <= w_binNext;
        if (w_last) begin
          r_bcdOut <= w_bcdNext;
          r_done   <= 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------- display scan
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_refCnt  <= '0;
      r_scanIdx <= 3'd0;
    end else if (r_refCnt == c_cntMax) begin
      r_refCnt  <= '0;
      r_scanIdx <= (r_scanIdx == 3'd5) ? 3'd0 : r_scanIdx + 3'd1;
    end else begin
      r_refCnt <= r_refCnt + 1'b1;
    end
  end

  function automatic logic [6:0] segOf(input logic [3:0] d);
    case (d)
      4'd0:    segOf = 7'b1000000;
      4'd1:    segOf = 7'b1111001;
      4'd2:    segOf = 7'b0100100;
      4'd3:    segOf = 7'b0110000;
      4'd4:    segOf = 7'b0011001;
      4'd5:    segOf = 7'b0010010;
      4'd6:    segOf = 7'b0000010;
      4'd7:    segOf = 7'b1111000;
      4'd8:    segOf = 7'b0000000;
      4'd9:    segOf = 7'b0010000;
      default: segOf = 7'b1111111;
    endcase
  endfunction

  // Digits at and above the scan position; all-zero means a leading zero.
  assign w_upper = r_bcdOut >> {r_scanIdx, 2'b00};
  assign w_blank = c_blankLz && (r_scanIdx != 3'd0) && (w_upper == 20'd0);

  assign an = ~(6'b000001 << r_scanIdx);

  always_comb begin
    seg = segOf(w_upper[3:0]);
    if (r_scanIdx == 3'd5) seg = w_signSeg;
    else if (w_blank)      seg = c_segBlank;
  end

endmodule
`default_nettype wire

// File: tb/tb_acc_display.sv
`default_nettype none
// Directed bench for acc_display: conversion table, handshake corners, scan content.
module tb_acc_display;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [15:0] value;
  logic        busy, done, neg;
  logic [19:0] bcd_out;
  logic [5:0]  an;
  logic [6:0]  seg;

  always #5 clk = ~clk;

  acc_display #(.REFRESH_DIV(DIV), .BLANK_LZ(1)) dut (
    .clk(clk), .reset(reset), .load(load), .value(value),
    .busy(busy), .done(done), .bcd_out(bcd_out), .neg(neg),
    .an(an), .seg(seg)
  );

  int nCompared = 0;
  int nMismatch = 0;
  int ticks = 0;
  logic [19:0] lastBcd = 20'd0;

  typedef struct {
    logic [15:0] v;
    logic [19:0] bcd;
    logic        ng;
  } vec_t;
  vec_t vecs[12];

  task automatic tick();
    @(posedge clk);
    #1;
    ticks++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatch++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic startLoad(input logic [15:0] v);
    value = v;
    load  = 1'b1;
    tick();
    load  = 1'b0;
  endtask

  // Counts edges until done; bcd_out must not move while busy.
  task automatic waitDone(input string name, input int expLat);
    int  lat;
    bit  seen;
    lat  = 0;
    seen = 0;
    for (int i = 0; i < 24 && !seen; i++) begin
      tick();
      lat++;
      if (done) seen = 1;
      else if (i == 7) check({name, " hold"}, bcd_out, lastBcd);
    end
    check({name, " latency"}, lat, expLat);
    check({name, " busyLow"}, busy, 0);
  endtask

  task automatic convert(input string name, input logic [15:0] v,
                         input logic [19:0] expBcd, input logic expNeg);
    startLoad(v);
    check({name, " busy"}, busy, 1);
    waitDone(name, 16);
    check({name, " bcd"}, bcd_out, expBcd);
    check({name, " neg"}, neg, expNeg);
    lastBcd = expBcd;
    tick();
    check({name, " donePulse"}, done, 0);
  endtask

  // segs = {s5,s4,s3,s2,s1,s0}; position derived from edges since reset release.
  task automatic scanCheck(input string name, input logic [41:0] segs);
    int idx;
    logic [5:0] expAn;
    for (int i = 0; i < 6 * DIV; i++) begin
      idx   = (ticks / DIV) % 6;
      expAn = ~(6'b000001 << idx);
      check({name, " an"}, an, expAn);
      check({name, " seg"}, seg, segs[idx*7 +: 7]);
      tick();
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{16'd0,     20'h00000, 1'b0};
    vecs[1]  = '{16'd1,     20'h00001, 1'b0};
    vecs[2]  = '{16'd9,     20'h00009, 1'b0};
    vecs[3]  = '{16'd10,    20'h00010, 1'b0};
    vecs[4]  = '{16'd99,    20'h00099, 1'b0};
    vecs[5]  = '{16'd1234,  20'h01234, 1'b0};
    vecs[6]  = '{16'd9999,  20'h09999, 1'b0};
    vecs[7]  = '{16'd10000, 20'h10000, 1'b0};
    vecs[8]  = '{16'd65535, 20'h65535, 1'b0};
`ifdef SIGNED_DISPLAY_EN
    vecs[8]  = '{16'd65535, 20'h00001, 1'b1};
    vecs[9]  = '{16'hFFF6,  20'h00010, 1'b1};
    vecs[10] = '{16'h8000,  20'h32768, 1'b1};
`else
    vecs[9]  = '{16'hFFF6,  20'h65526, 1'b0};
    vecs[10] = '{16'h8000,  20'h32768, 1'b0};
`endif
    vecs[11] = '{16'd32767, 20'h32767, 1'b0};

    reset = 1'b1;
    load  = 1'b0;
    value = 16'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst bcd", bcd_out, 0);
    check("rst neg", neg, 0);
    check("rst an", an, 6'b111110);
    check("rst seg", seg, 7'b1000000);
    reset = 1'b0;
    ticks = 0;

    foreach (vecs[k]) convert($sformatf("vec%0d", k), vecs[k].v, vecs[k].bcd, vecs[k].ng);

    // load while busy is dropped
    startLoad(16'd1234);
    repeat (4) tick();
    value = 16'd999;
    load  = 1'b1;
    tick();
    load  = 1'b0;
    check("ignore busy", busy, 1);
    waitDone("ignore", 11);
    check("ignore bcd", bcd_out, 20'h01234);
    lastBcd = 20'h01234;

    // load accepted in the done cycle
    check("doneLoad done", done, 1);
    startLoad(16'd500);
    check("doneLoad busy", busy, 1);
    check("doneLoad doneLow", done, 0);
    waitDone("doneLoad", 16);
    check("doneLoad bcd", bcd_out, 20'h00500);
    lastBcd = 20'h00500;
    tick();

    convert("scan1234", 16'd1234, 20'h01234, 1'b0);
    scanCheck("scan1234", {7'b1111111, 7'b1111111, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001});

    convert("scan10000", 16'd10000, 20'h10000, 1'b0);
    scanCheck("scan10000", {7'b1111111, 7'b1111001, 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000});

`ifdef SIGNED_DISPLAY_EN
    convert("scanNeg", 16'hFFF6, 20'h00010, 1'b1);
    scanCheck("scanNeg", {7'b0111111, 7'b1111111, 7'b1111111, 7'b1111111, 7'b1111001, 7'b1000000});
`else
    convert("scanNeg", 16'hFFF6, 20'h65526, 1'b0);
    scanCheck("scanNeg", {7'b1111111, 7'b0000010, 7'b0010010, 7'b0010010, 7'b0100100, 7'b0000010});
`endif

    // asynchronous reset in the middle of a conversion, then recovery
    startLoad(16'd30000);
    repeat (7) tick();
    check("midRst busyBefore", busy, 1);
    reset = 1'b1;
    #1;
    check("midRst busy", busy, 0);
    check("midRst done", done, 0);
    check("midRst bcd", bcd_out, 0);
    check("midRst neg", neg, 0);
    check("midRst an", an, 6'b111110);
    check("midRst seg", seg, 7'b1000000);
    tick();
    reset = 1'b0;
    ticks = 0;
    lastBcd = 20'd0;
    convert("after rst", 16'd42, 20'h00042, 1'b0);
    scanCheck("scan42", {7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111, 7'b0011001, 7'b0100100});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
`default_nettype wire
